gray_counter: RTL and testbench

Synchronous up/down binary counter with a registered Gray-code output. It is the encode-side companion to the Gray-to-binary converter and is intended for pointers that cross clock domains, such as async FIFO read/write pointers. Only one Gray bit toggles per count step, and the output comes straight from flops, so it is glitch-free.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/bin2gray.sv | 17 +
 rtl/gray_counter.sv | 77 +++++++
 tb/tb_gray_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants and Gray-code helper functions
//
// Purpose: default counter width plus bin2gray/gray2bin helpers for
// reference models and round-trip checks (up to 16 bits, zero-extended).
// Ports: none (package).

package gray_pkg;

   localparam int GRAY_W_DEFAULT = 4;

   function automatic logic [15:0] bin2gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [15:0] gray2bin(input logic [15:0] g);
      logic [15:0] b;
      b[15] = g[15];
      for (int i = 14; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - combinational binary-to-Gray encoder
//
// Purpose: gray_out = bin_in ^ (bin_in >> 1), no state.
// Ports:
//   bin_in   in  WIDTH  binary value
//   gray_out out WIDTH  Gray code of bin_in

module bin2gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin_in,
   output logic [WIDTH-1:0] gray_out
);

   assign gray_out = bin_in ^ (bin_in >> 1);

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered Gray output
//
// Purpose: counter for clock-domain-crossing pointers. The Gray output
// comes straight from flops and changes one bit per counted step.
// Ports:
//   clk      in  1      rising-edge clock
//   rst_n    in  1      asynchronous active-low reset
//   clr      in  1      synchronous clear (highest priority)
//   load     in  1      synchronous load of load_val
//   load_val in  WIDTH  binary value to load
//   en       in  1      count enable
//   up_dn    in  1      1 = increment, 0 = decrement
//   bin      out WIDTH  registered binary count
//   gray     out WIDTH  registered Gray code of bin
//   wrap     out 1      one-cycle pulse after a modular wrap-around

module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gray_nxt;
   logic             wrap_nxt;

   // Priority: clr > load > en > hold. Wrap is flagged only for counted
   // steps that cross the all-ones/zero boundary, never for clr/load.
   always_comb begin
      bin_nxt  = bin;
      wrap_nxt = 1'b0;
      if (clr) begin
         bin_nxt = '0;
      end else if (load) begin
         bin_nxt = load_val;
      end else if (en) begin
         if (up_dn) begin
            bin_nxt  = bin + WIDTH'(1);
            wrap_nxt = &bin;
         end else begin
            bin_nxt  = bin - WIDTH'(1);
            wrap_nxt = ~|bin;
         end
      end
   end

   // Encode the next binary value so gray lands in the same edge as bin;
   // re-encoding the registered bin would lag it by a cycle.
   bin2gray #(.WIDTH(WIDTH)) u_enc (
      .bin_in   (bin_nxt),
      .gray_out (gray_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin  <= '0;
         gray <= '0;
         wrap <= 1'b0;
      end else begin
         bin  <= bin_nxt;
         gray <= gray_nxt;
         wrap <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter (WIDTH=4)

module tb_gray_counter;
   import gray_pkg::*;

   localparam int W = 4;
   localparam int MOD = 16;

   localparam logic [3:0] SEQ [16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
   };

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic         load;
   logic [W-1:0] load_val;
   logic         en;
   logic         up_dn;
   logic [W-1:0] bin;
   logic [W-1:0] gray;
   logic         wrap;

   int passed = 0;
   int total  = 0;

   gray_counter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .up_dn    (up_dn),
      .bin      (bin),
      .gray     (gray),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
      step();
      total++; if (bin !== 4'd0) $display("FAIL reset_bin got=%b exp=0000", bin); else passed++;
      total++; if (gray !== 4'd0) $display("FAIL reset_gray got=%b exp=0000", gray); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_count_up();
      en = 1'b1; up_dn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         total++;
         if (gray !== SEQ[i % 16]) $display("FAIL up_gray step=%0d got=%b exp=%b", i, gray, SEQ[i % 16]);
         else passed++;
         total++;
         if (wrap !== (i == 16)) $display("FAIL up_wrap step=%0d got=%b exp=%b", i, wrap, (i == 16));
         else passed++;
         total++;
         if (gray2bin({12'd0, gray}) !== {12'd0, bin})
            $display("FAIL up_roundtrip step=%0d bin=%b gray=%b", i, bin, gray);
         else passed++;
      end
      en = 1'b0;
   endtask

   task automatic test_count_down();
      rst_n = 1'b0; #1; rst_n = 1'b1;
      en = 1'b1; up_dn = 1'b0;
      step();
      total++; if (bin !== 4'b1111) $display("FAIL down1_bin got=%b exp=1111", bin); else passed++;
      total++; if (gray !== 4'b1000) $display("FAIL down1_gray got=%b exp=1000", gray); else passed++;
      total++; if (wrap !== 1'b1) $display("FAIL down1_wrap got=%b exp=1", wrap); else passed++;
      step();
      total++; if (bin !== 4'b1110) $display("FAIL down2_bin got=%b exp=1110", bin); else passed++;
      total++; if (gray !== 4'b1001) $display("FAIL down2_gray got=%b exp=1001", gray); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL down2_wrap got=%b exp=0", wrap); else passed++;
      en = 1'b0;
   endtask

   task automatic test_load();
      load = 1'b1; load_val = 4'b1010; en = 1'b1; up_dn = 1'b1;
      step();
      total++; if (bin !== 4'b1010) $display("FAIL load_bin got=%b exp=1010", bin); else passed++;
      total++; if (gray !== 4'b1111) $display("FAIL load_gray got=%b exp=1111", gray); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL load_wrap got=%b exp=0", wrap); else passed++;
      load = 1'b0;
      step();
      total++; if (bin !== 4'b1011) $display("FAIL load_next_bin got=%b exp=1011", bin); else passed++;
      total++; if (gray !== 4'b1110) $display("FAIL load_next_gray got=%b exp=1110", gray); else passed++;
      en = 1'b0;
   endtask

   task automatic test_clr_priority();
      load = 1'b1; load_val = 4'b0111; en = 1'b0;
      step();
      total++; if (bin !== 4'b0111) $display("FAIL clr_setup_bin got=%b exp=0111", bin); else passed++;
      clr = 1'b1; load = 1'b1; load_val = 4'b1111; en = 1'b1; up_dn = 1'b1;
      step();
      total++; if (bin !== 4'd0) $display("FAIL clr_bin got=%b exp=0000", bin); else passed++;
      total++; if (gray !== 4'd0) $display("FAIL clr_gray got=%b exp=0000", gray); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL clr_wrap got=%b exp=0", wrap); else passed++;
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_async_reset();
      clr = 1'b1; step(); clr = 1'b0;
      en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 5; i++) step();
      en = 1'b0;
      total++; if (bin !== 4'b0101) $display("FAIL arst_setup_bin got=%b exp=0101", bin); else passed++;
      #2; rst_n = 1'b0; #1;
      total++; if (bin !== 4'd0) $display("FAIL arst_bin got=%b exp=0000", bin); else passed++;
      total++; if (gray !== 4'd0) $display("FAIL arst_gray got=%b exp=0000", gray); else passed++;
      total++; if (wrap !== 1'b0) $display("FAIL arst_wrap got=%b exp=0", wrap); else passed++;
      en = 1'b1;
      step();
      total++; if (bin !== 4'd0) $display("FAIL arst_hold_bin got=%b exp=0000", bin); else passed++;
      rst_n = 1'b1;
      step();
      total++; if (bin !== 4'b0001) $display("FAIL arst_resume_bin got=%b exp=0001", bin); else passed++;
      total++; if (gray !== 4'b0001) $display("FAIL arst_resume_gray got=%b exp=0001", gray); else passed++;
      en = 1'b0;
   endtask

   task automatic test_random();
      int m;
      bit w;
      bit en_only;
      logic [W-1:0] gray_prev;
      clr = 1'b1; step(); clr = 1'b0;
      m = 0;
      for (int c = 0; c < 10000; c++) begin
         clr      = ($urandom_range(0, 99) < 3);
         load     = ($urandom_range(0, 99) < 10);
         load_val = 4'($urandom_range(0, 15));
         en       = ($urandom_range(0, 99) < 75);
         up_dn    = 1'($urandom_range(0, 1));
         en_only  = !clr && !load && en;
         gray_prev = gray;
         if (clr) begin
            m = 0; w = 1'b0;
         end else if (load) begin
            m = int'(load_val); w = 1'b0;
         end else if (en && up_dn) begin
            w = (m + 1 == MOD); m = (m + 1) % MOD;
         end else if (en) begin
            w = (m == 0); m = (m + MOD - 1) % MOD;
         end else begin
            w = 1'b0;
         end
         step();
         total++;
         if (bin !== 4'(m)) $display("FAIL rnd_bin cyc=%0d got=%b exp=%b", c, bin, 4'(m));
         else passed++;
         total++;
         if (gray !== 4'(m ^ (m >> 1))) $display("FAIL rnd_gray cyc=%0d got=%b exp=%b", c, gray, 4'(m ^ (m >> 1)));
         else passed++;
         total++;
         if (wrap !== w) $display("FAIL rnd_wrap cyc=%0d got=%b exp=%b", c, wrap, w);
         else passed++;
         if (en_only) begin
            total++;
            if ($countones(gray_prev ^ gray) != 1)
               $display("FAIL rnd_onebit cyc=%0d prev=%b now=%b exp=1 bit change", c, gray_prev, gray);
            else passed++;
         end
      end
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_clr_priority();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
